// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath.
// Ports: clk, reset (async, active-low), Opcode, mem_ready -> datapath controls, pulses, state.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic is_i;
  logic is_r;
  logic is_lw;
  logic is_sw;
  logic is_br;
  logic is_bad;
  logic mem_st;
  logic timeout;

  assign is_i   = (Opcode == OP_I);
  assign is_r   = (Opcode == OP_R);
  assign is_lw  = (Opcode == OP_LW);
  assign is_sw  = (Opcode == OP_SW);
  assign is_br  = (Opcode == OP_BR);
  assign is_bad = !(is_i | is_r | is_lw | is_sw | is_br);

  assign mem_st = (state_q == S_FETCH) ||
                  (state_q == S_MEMREAD) ||
                  (state_q == S_MEMWRITE);

  // A completed access in the last allowed cycle wins over the abort.
  assign timeout = mem_st && !mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADR;
          is_r:         state_d = S_EXEC_R;
          is_i:         state_d = S_EXEC_I;
          is_br:        state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = is_sw ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWB:
        state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready || timeout)
          state_d = S_FETCH;
      end
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // FETCH->FETCH after an abort is not a state change, so the
  // timeout itself also clears the counter for the retry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || timeout)
      cnt_d = '0;
    else if (mem_st && !mem_ready && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset gates every output combinationally so they drop at once.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    Branch     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    state      = 4'd0;
    if (reset) begin
      state   = state_q;
      mem_err = timeout;
      unique case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b10;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b01;
          illegal_op = is_bad;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite   = 1'b1;
          AdrSrc     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXEC_I: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA    = 2'b10;
          ALUOp      = 2'b01;
          Branch     = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cases plus random opcodes
// and mem_ready, checked against an instruction-path reference model.
module tb_multicycle_controller;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] Opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IRWrite, AdrSrc, MemRead, MemWrite;
  logic       RegWrite, MemtoReg, Branch;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_done, illegal_op, mem_err;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode),
    .mem_ready(mem_ready), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .Branch(Branch),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_err(mem_err), .state(state)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h",
               tag, $time, got, exp);
    end
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;

  int         path[$];
  int         waited = 0;
  logic [6:0] cur_op = 7'd0;
  logic [6:0] forced[$];
  int         done_exp = 0;
  int         done_seen = 0;

  always @(posedge clk)
    if (instr_done === 1'b1) done_seen++;

  function automatic logic legal(input logic [6:0] op);
    return op == R || op == I || op == LW ||
           op == SW || op == BR;
  endfunction

  function automatic logic is_mem(input int p);
    return p == 0 || p == 3 || p == 5;
  endfunction

  // Sequence of state codes an instruction walks through.
  task automatic plan(input logic [6:0] op);
    path = '{0, 1};
    if (op == R)       path = '{0, 1, 6, 8};
    else if (op == I)  path = '{0, 1, 7, 8};
    else if (op == LW) path = '{0, 1, 2, 3, 4};
    else if (op == SW) path = '{0, 1, 2, 5};
    else if (op == BR) path = '{0, 1, 9};
  endtask

  function automatic logic [20:0] expect_word(
      input int p, input logic rdy,
      input int w, input logic [6:0] op);
    logic pcw, irw, adr, mr, mw, rw, m2r;
    logic br, dn, il, er;
    logic [1:0] sa, sb, ao;
    {pcw, irw, adr, mr, mw, rw, m2r} = '0;
    {br, dn, il, er} = '0;
    {sa, sb, ao} = '0;
    case (p)
      0: begin mr = 1; sb = 2'b10; pcw = rdy; irw = rdy; end
      1: begin sa = 2'b01; sb = 2'b01; il = !legal(op); end
      2: begin sa = 2'b10; sb = 2'b01; end
      3: begin mr = 1; adr = 1; end
      4: begin rw = 1; m2r = 1; dn = 1; end
      5: begin mw = 1; adr = 1; dn = rdy; end
      6: begin sa = 2'b10; ao = 2'b10; end
      7: begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      8: begin rw = 1; dn = 1; end
      9: begin sa = 2'b10; ao = 2'b01; br = 1; dn = 1; end
      default: ;
    endcase
    er = is_mem(p) && !rdy && (w == TO - 1);
    return {4'(p), pcw, irw, adr, mr, mw, rw, m2r,
            sa, sb, ao, br, dn, il, er};
  endfunction

  function automatic logic [20:0] obs();
    return {state, PCWrite, IRWrite, AdrSrc, MemRead,
            MemWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
            ALUOp, Branch, instr_done, illegal_op, mem_err};
  endfunction

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [5];
    ops = '{R, I, LW, SW, BR};
    if ($urandom_range(0, 9) == 0)
      return 7'($urandom);
    return ops[$urandom_range(0, 4)];
  endfunction

  // Called at a falling edge; leaves at the next falling edge.
  task automatic step(input logic rdy);
    logic [20:0] exp;
    int p;
    if (path.size() == 0) begin
      cur_op = (forced.size() != 0) ? forced.pop_front()
                                    : rand_op();
      plan(cur_op);
    end
    Opcode = cur_op;
    mem_ready = rdy;
    #1;
    p = path[0];
    exp = expect_word(p, rdy, waited, cur_op);
    chk("ctl", 32'(obs()), 32'(exp));
    chk("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
    if (exp[2]) done_exp++;
    if (exp[0]) begin
      waited = 0;
      if (p != 0) path.delete();
    end else if (is_mem(p) && !rdy) begin
      waited++;
    end else begin
      path.delete(0);
      waited = 0;
    end
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b0;
    #1 chk("rst_async", 32'(obs()), 32'd0);
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 chk("rst_hold", 32'(obs()), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    path.delete();
    waited = 0;
  endtask

  task automatic run(input logic [6:0] op,
                     input logic rdys[$]);
    forced.push_back(op);
    foreach (rdys[k]) step(rdys[k]);
  endtask

  initial begin
    #1 chk("rst_init", 32'(obs()), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_init_hold", 32'(obs()), 32'd0);
    reset = 1'b1;

    run(R, '{1, 1, 1, 1});
    run(LW, '{1, 1, 1, 0, 0, 1, 1});
    run(SW, '{1, 1, 1, 1});
    run(BR, '{1, 1, 1});
    run(7'h7f, '{1, 1});
    run(R, '{0, 0, 0, 0, 1, 1, 1, 1});
    run(LW, '{1, 1, 1, 0, 0, 0, 0});
    run(SW, '{1, 0, 1, 0, 0, 0, 0});
    run(LW, '{1, 1, 1, 0});
    mid_reset();
    run(I, '{1, 1, 1, 1});

    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 199) == 0) mid_reset();
    end

    chk("done_count", 32'(done_seen), 32'(done_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
